mgt_01_fp_mag_unit: RTL and testbench
=====================================

# mgt_01_fp_mag_unit

Single-precision (IEEE-754 binary32) min/max unit for the RV32IMF floating-point datapath. It implements the RISC-V F-extension FMIN.S/FMAX.S semantics, including NaN handling, signed-zero ordering and the invalid-operation flag. The registered result goes to the rounding stage over `to_round_unit_o`. Overflow and underflow outputs exist for interface uniformity with the other FP units.

## Interface
- No parameters.
- `clk_i` in 1: clock, rising-edge active.
- `rst_i` in 1: reset, asynchronous, active-high.
- `clk_en_i` in 1: clock enable. When low, all output registers hold their value.
- `operand_A_i` in 32: operand A (`float_t`: sign[31], exponent[30:23], mantissa[22:0]).
- `operand_B_i` in 32: operand B (`float_t`).
- `operation_i` in `fcmp_ops`: operation select. `FMAX_` selects max; `FMIN_` selects min. Any other encoding behaves as `FMIN_`.
- `to_round_unit_o` out 32: result (`float_t`), registered.
- `invalid_op_o` out 1: IEEE invalid-operation flag, registered.
- `overflow_o` out 1: always 0.
- `underflow_o` out 1: always 0.

## Operation
- Classification per operand:
  - NaN: exponent = 0xFF and mantissa ≠ 0.
  - sNaN: a NaN with mantissa[22] = 0.
  - qNaN: a NaN with mantissa[22] = 1.
- Ordering is total over non-NaN values: −inf < negatives < −0 < +0 < positives < +inf.
  - Different signs: the negative operand is smaller; −0 is smaller than +0.
  - Both positive: the operand with the larger {exponent, mantissa} is larger.
  - Both negative: the operand with the larger {exponent, mantissa} is smaller.
  - Equal bit patterns: return operand A.
- Result selection:
  - Neither operand NaN: max (FMAX) or min (FMIN) under the ordering above.
  - Exactly one operand NaN (quiet or signaling): return the other operand, bit-exact.
  - Both operands NaN: return the canonical NaN 0x7FC00000.
- `invalid_op_o` = 1 iff at least one operand is an sNaN, for both FMIN and FMAX. A qNaN alone never raises it.
- The result is never rounded or modified. Denormals and infinities pass through unchanged.
- `overflow_o` and `underflow_o` are tied to 0 in every case.

## Timing
- Combinational compare and select feed one output register stage.
- Latency is 1 cycle: inputs sampled at rising edge N (with `clk_en_i` = 1) appear on the outputs after edge N. Inputs must be stable at that edge.
- `clk_en_i` = 0: the register holds. Input changes while disabled have no effect.
- There is no handshake; a new operation may be issued every enabled cycle (throughput 1/cycle).
- Reset (`rst_i` = 1), effective immediately and regardless of the clock or `clk_en_i`:
  - `to_round_unit_o` = 0x00000000.
  - `invalid_op_o` = 0, `overflow_o` = 0, `underflow_o` = 0.
- Reset asserted mid-operation discards the in-flight result. The first valid result appears one enabled edge after reset is released.
- Changing `operation_i` in the same cycle as the operands is legal. Both are sampled together.

## Test plan
- FMAX on A = 0x40F224DD (7.567), B = 0x40BD70A4 (5.92) -> result 0x40F224DD, invalid 0. Then A = 0x3F99999A (1.2), same B -> result 0x40BD70A4.
- FMIN on 7.567/5.92 -> result 0x40BD70A4. FMIN on 1.2/5.92 -> result 0x3F99999A. Both with invalid 0.
- FMAX or FMIN with A = qNaN 0x7FC00000, B = 5.92 -> result 0x40BD70A4, invalid 0.
- FMIN and FMAX with A = sNaN 0x7FA00000, B = 5.92 -> result 0x40BD70A4, invalid 1.
- FMIN with both operands sNaN 0x7FA00000 -> result 0x7FC00000, invalid 1.
- FMIN with A = 5.92, B = −inf 0xFF800000 -> result 0xFF800000, overflow 0, underflow 0.
- FMIN(+0, −0) -> 0x80000000 and FMAX(+0, −0) -> 0x00000000.
- Negative operands: FMAX(0xC0000000 = −2, 0xBF800000 = −1) -> 0xBF800000.
- `clk_en_i` low: outputs hold across operand changes.
- Asserting `rst_i` between edges clears all outputs immediately.

Source files
------------

// File: rtl/mgt_01_fp_mag_unit.sv
`default_nettype none
// ============================================================================
// Module      : mgt_01_fp_mag_unit (+ mgt_01_fp_mag_unit_pkg)
// Description : binary32 FMIN.S / FMAX.S with NaN handling, signed-zero
//               ordering and invalid flag; one output register stage.
// Revision    : 1.0 - initial release
// ============================================================================

package mgt_01_fp_mag_unit_pkg;
    typedef enum logic [1:0] {
        FMIN_ = 2'd0,
        FMAX_ = 2'd1,
        FRSV2 = 2'd2,
        FRSV3 = 2'd3
    } fcmp_ops;

    localparam logic [31:0] C_CANON_NAN = 32'h7FC0_0000;
endpackage

module mgt_01_fp_mag_unit
    import mgt_01_fp_mag_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic [31:0] operand_A_i,
    input  logic [31:0] operand_B_i,
    input  fcmp_ops     operation_i,
    output logic [31:0] to_round_unit_o,
    output logic        invalid_op_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_snan;
    logic        w_b_snan;
    logic        w_a_lt_b;
    logic        w_b_lt_a;
    logic        w_is_max;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        invalid_d;
    logic        invalid_q;

    always_comb begin
        w_a_nan  = (operand_A_i[30:23] == 8'hFF) && (operand_A_i[22:0] != 23'd0);
        w_b_nan  = (operand_B_i[30:23] == 8'hFF) && (operand_B_i[22:0] != 23'd0);
        w_a_snan = w_a_nan && !operand_A_i[22];
        w_b_snan = w_b_nan && !operand_B_i[22];
        w_is_max = (operation_i == FMAX_);

        // Magnitude order flips for negatives; a sign mismatch alone decides,
        // which also places -0 below +0.
        if (operand_A_i[31] != operand_B_i[31]) begin
            w_a_lt_b = operand_A_i[31];
        end else if (!operand_A_i[31]) begin
            w_a_lt_b = operand_A_i[30:0] < operand_B_i[30:0];
        end else begin
            w_a_lt_b = operand_A_i[30:0] > operand_B_i[30:0];
        end
        w_b_lt_a = !w_a_lt_b && (operand_A_i != operand_B_i);

        if (w_a_nan && w_b_nan) begin
            result_d = C_CANON_NAN;
        end else if (w_a_nan) begin
            result_d = operand_B_i;
        end else if (w_b_nan) begin
            result_d = operand_A_i;
        end else if (w_is_max) begin
            result_d = w_a_lt_b ? operand_B_i : operand_A_i;
        end else begin
            result_d = w_b_lt_a ? operand_B_i : operand_A_i;
        end

        invalid_d = w_a_snan || w_b_snan;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q  <= 32'h0000_0000;
            invalid_q <= 1'b0;
        end else if (clk_en_i) begin
            result_q  <= result_d;
            invalid_q <= invalid_d;
        end
    end

    assign to_round_unit_o = result_q;
    assign invalid_op_o    = invalid_q;
    assign overflow_o      = 1'b0;
    assign underflow_o     = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_mgt_01_fp_mag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mgt_01_fp_mag_unit
// Description : directed + randomized self-checking bench for the min/max unit.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mgt_01_fp_mag_unit;
    import mgt_01_fp_mag_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [31:0] op_a;
    logic [31:0] op_b;
    fcmp_ops     op_sel;
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        unf;

    int n_tests;
    int n_fail;

    logic [31:0] exp_res;
    logic        exp_inv;

    mgt_01_fp_mag_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clk_en_i       (clk_en),
        .operand_A_i    (op_a),
        .operand_B_i    (op_b),
        .operation_i    (op_sel),
        .to_round_unit_o(res),
        .invalid_op_o   (inv),
        .overflow_o     (ovf),
        .underflow_o    (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position on the real line as a signed integer: -0 maps just below +0.
    function automatic longint order_key(input logic [31:0] x);
        longint mag;
        mag = longint'({33'd0, x[30:0]});
        return x[31] ? (-mag - 1) : mag;
    endfunction

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        bit an, bn, sa, sb, is_max;
        logic [31:0] r;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sa = an && !a[22];
        sb = bn && !b[22];
        is_max = (op == 2'd1);
        if (an && bn)      r = 32'h7FC0_0000;
        else if (an)       r = b;
        else if (bn)       r = a;
        else if (is_max)   r = (order_key(a) >= order_key(b)) ? a : b;
        else               r = (order_key(a) <= order_key(b)) ? a : b;
        return {sa || sb, r};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_res <= 32'h0;
            exp_inv <= 1'b0;
        end else if (clk_en) begin
            {exp_inv, exp_res} <= model(op_a, op_b, op_sel);
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if (res !== exp_res || inv !== exp_inv || ovf !== 1'b0 || unf !== 1'b0) begin
            n_fail++;
            $display("FAIL cycle_model: got res=%h inv=%b ovf=%b unf=%b, want res=%h inv=%b ovf=0 unf=0",
                     res, inv, ovf, unf, exp_res, exp_inv);
        end
    end

    task automatic check_lit(input string name, input logic [31:0] er, input logic ei);
        n_tests++;
        if (res !== er || inv !== ei || ovf !== 1'b0 || unf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got res=%h inv=%b ovf=%b unf=%b, want res=%h inv=%b",
                     name, res, inv, ovf, unf, er, ei);
        end
        n_tests++;
        if (exp_res !== er || exp_inv !== ei) begin
            n_fail++;
            $display("FAIL %s_model: got res=%h inv=%b, want res=%h inv=%b",
                     name, exp_res, exp_inv, er, ei);
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input fcmp_ops o, input logic [31:0] er, input logic ei);
        op_a   = a;
        op_b   = b;
        op_sel = o;
        @(posedge clk);
        #1;
        check_lit(name, er, ei);
    endtask

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v = {v[31], 8'hFF, 1'b1, v[21:0]};
            1: v = {v[31], 8'hFF, 1'b0, v[21:1], 1'b1};
            2: v = {v[31], 31'd0};
            3: v = {v[31], 8'hFF, 23'd0};
            4: v = other;
            5: v = {other[31:8], v[7:0]};
            6: v = {v[31], 8'd0, v[22:0]};
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clk_en  = 1'b1;
        op_a    = 32'h0;
        op_b    = 32'h0;
        op_sel  = FMIN_;
        @(posedge clk);
        #1;
        check_lit("reset_state", 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        do_op("fmax_big",   32'h40F224DD, 32'h40BD70A4, FMAX_, 32'h40F224DD, 1'b0);
        do_op("fmax_small", 32'h3F99999A, 32'h40BD70A4, FMAX_, 32'h40BD70A4, 1'b0);
        do_op("fmin_big",   32'h40F224DD, 32'h40BD70A4, FMIN_, 32'h40BD70A4, 1'b0);
        do_op("fmin_small", 32'h3F99999A, 32'h40BD70A4, FMIN_, 32'h3F99999A, 1'b0);
        do_op("fmax_qnan",  32'h7FC00000, 32'h40BD70A4, FMAX_, 32'h40BD70A4, 1'b0);
        do_op("fmin_qnan",  32'h7FC00000, 32'h40BD70A4, FMIN_, 32'h40BD70A4, 1'b0);
        do_op("fmin_snan",  32'h7FA00000, 32'h40BD70A4, FMIN_, 32'h40BD70A4, 1'b1);
        do_op("fmax_snan",  32'h7FA00000, 32'h40BD70A4, FMAX_, 32'h40BD70A4, 1'b1);
        do_op("fmin_2snan", 32'h7FA00000, 32'h7FA00000, FMIN_, 32'h7FC00000, 1'b1);
        do_op("fmin_ninf",  32'h40BD70A4, 32'hFF800000, FMIN_, 32'hFF800000, 1'b0);
        do_op("fmin_zeros", 32'h00000000, 32'h80000000, FMIN_, 32'h80000000, 1'b0);
        do_op("fmax_zeros", 32'h00000000, 32'h80000000, FMAX_, 32'h00000000, 1'b0);
        do_op("fmax_negs",  32'hC0000000, 32'hBF800000, FMAX_, 32'hBF800000, 1'b0);
        do_op("fmin_negs",  32'hC0000000, 32'hBF800000, FMIN_, 32'hC0000000, 1'b0);
        do_op("rsv_is_min", 32'h40F224DD, 32'h40BD70A4, FRSV3, 32'h40BD70A4, 1'b0);
        do_op("snan_b",     32'h3F99999A, 32'hFF800001, FMAX_, 32'h3F99999A, 1'b1);

        clk_en = 1'b0;
        do_op("hold_1", 32'h7FA00000, 32'h7FA00000, FMAX_, 32'h3F99999A, 1'b1);
        do_op("hold_2", 32'h00000000, 32'hFF800000, FMIN_, 32'h3F99999A, 1'b1);
        clk_en = 1'b1;
        do_op("release", 32'h00000000, 32'hFF800000, FMIN_, 32'hFF800000, 1'b0);
        do_op("set_inv", 32'h7F800001, 32'h00000001, FMIN_, 32'h00000001, 1'b1);

        #2;
        rst = 1'b1;
        #1;
        check_lit("async_rst", 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_lit("rst_release", 32'h0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            op_a   = rand_operand($urandom);
            op_b   = rand_operand(op_a);
            op_sel = fcmp_ops'(2'($urandom_range(0, 3)));
            clk_en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #3;
                rst = 1'b0;
            end
        end

        @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
